// File: rtl/sr_imem_loader_pkg.sv
// Shared constants and helpers for the instruction-memory loader:
// FSM encoding, default depth and little-endian byte merge.
package sr_imem_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } ld_state_e;

  // Places byte b at lane idx above the already-assembled lower lanes;
  // lanes above idx read as zero so a short final word is zero-padded.
  function automatic logic [31:0] merge_byte(input logic [23:0] partial,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {24'h000000, b};
      2'd1:    w = {16'h0000, b, partial[7:0]};
      2'd2:    w = {8'h00, b, partial[15:0]};
      default: w = {b, partial};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sr_imem_ram.sv
// Instruction RAM: synchronous write, asynchronous read, no reset.
// A read of the address being written returns the old word until the edge.
module sr_imem_ram #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction memory with a byte-stream load port; holds sr_cpu in reset
// while a program is streamed in, then releases it.
module sr_imem_loader
  import sr_imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           imAddr,
  output logic [31:0]           imData,
  output logic                  cpu_rst_n,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [7:0]            ld_data,
  input  logic                  ld_last,
  output logic                  ld_done,
  output logic                  ld_ovf,
  output logic [ADDR_WIDTH:0]   wordCount,
  output logic [1:0]            dbg_state
);

  // Handshake: a byte transfers on a rising edge where ld_valid && ld_ready.
  // ld_ready is high exactly in LOAD and does not depend on ld_valid; the
  // source must hold ld_data/ld_last stable while ld_valid is high and
  // ld_ready is low.

  ld_state_e             state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;

  logic                  full;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic                  unused_addr_bits;

  // The MSB of the word counter is set only at exactly 2^ADDR_WIDTH words.
  assign full = wcnt_q[ADDR_WIDTH];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    wcnt_d      = wcnt_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = merge_byte(asm_q, idx_q, ld_data);

    case (state_q)
      ST_HALT, ST_RUN: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          idx_d   = 2'd0;
          asm_d   = 24'h000000;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (idx_q == 2'd3 || ld_last) begin
            mem_we = 1'b1;
            wcnt_d = wcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            idx_d  = 2'd0;
            asm_d  = 24'h000000;
          end else begin
            asm_d = mem_wdata[23:0];
            idx_d = idx_q + 2'd1;
          end
          if (ld_last) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase

    cpu_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      idx_q       <= 2'd0;
      asm_q       <= 24'h000000;
      wcnt_q      <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      wcnt_q      <= wcnt_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  sr_imem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wcnt_q[ADDR_WIDTH-1:0]),
    .wdata_i (mem_wdata),
    .raddr_i (imAddr[ADDR_WIDTH-1:0]),
    .rdata_o (imData)
  );

  // Upper fetch-address bits alias onto the same words.
  assign unused_addr_bits = ^imAddr[31:ADDR_WIDTH];

  assign ld_ready  = (state_q == ST_LOAD);
  assign ld_done   = done_q;
  assign ld_ovf    = ovf_q;
  assign wordCount = wcnt_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Directed bench for sr_imem_loader: a default-depth instance (64 words) and
// a 4-word instance for the full boundary, selected by tb variable sel.
module tb_sr_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imAddr = 32'h0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        last = 1'b0;
  logic        sel = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_imData, b_imData;
  logic        a_cpu, b_cpu, a_ready, b_ready, a_done, b_done, a_ovf, b_ovf;
  logic [6:0]  a_wc;
  logic [2:0]  b_wc;
  logic [1:0]  a_st, b_st;

  logic [31:0] im_data;
  logic        cpu_rn, ready, done, ovf;
  logic [6:0]  wc;
  logic [1:0]  st;

  always #5 clk = ~clk;

  sr_imem_loader dut_a (
    .clk(clk), .rst_n(rst_n), .imAddr(imAddr), .imData(a_imData),
    .cpu_rst_n(a_cpu), .ld_start(start && !sel), .ld_valid(valid && !sel),
    .ld_ready(a_ready), .ld_data(data), .ld_last(last), .ld_done(a_done),
    .ld_ovf(a_ovf), .wordCount(a_wc), .dbg_state(a_st)
  );

  sr_imem_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .imAddr(imAddr), .imData(b_imData),
    .cpu_rst_n(b_cpu), .ld_start(start && sel), .ld_valid(valid && sel),
    .ld_ready(b_ready), .ld_data(data), .ld_last(last), .ld_done(b_done),
    .ld_ovf(b_ovf), .wordCount(b_wc), .dbg_state(b_st)
  );

  assign im_data = sel ? b_imData : a_imData;
  assign cpu_rn  = sel ? b_cpu : a_cpu;
  assign ready   = sel ? b_ready : a_ready;
  assign done    = sel ? b_done : a_done;
  assign ovf     = sel ? b_ovf : a_ovf;
  assign wc      = sel ? {4'b0000, b_wc} : a_wc;
  assign st      = sel ? b_st : a_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input logic l);
    logic r;
    int   n;
    valid = 1'b1;
    data  = b;
    last  = l;
    n     = 0;
    r     = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = ready;
      tick();
      n++;
    end
    if (!r) chk("byte_accept_timeout", 32'd0, 32'd1);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    imAddr = addr;
    #1;
    chk(tag, im_data, exp);
  endtask

  logic [7:0] prog [8];

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_cpu_rst_n", cpu_rn, 0);
    chk("rst_ld_ready", ready, 0);
    chk("rst_wordCount", wc, 0);
    chk("rst_ld_ovf", ovf, 0);
    chk("rst_ld_done", done, 0);
    chk("rst_state", st, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_cpu_rst_n", cpu_rn, 0);
    chk("idle_state", st, 0);

    // Full two-word load
    start_load();
    chk("load_state", st, 1);
    chk("load_ready", ready, 1);
    chk("load_cpu_rst_n", cpu_rn, 0);
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
    chk("full_done", done, 1);
    chk("full_cpu_rst_n", cpu_rn, 1);
    chk("full_state_run", st, 2);
    chk("full_ready_run", ready, 0);
    chk("full_wordCount", wc, 2);
    tick();
    chk("full_done_one_cycle", done, 0);
    chk("full_cpu_stays", cpu_rn, 1);
    read_chk("full_mem0", 32'h0, 32'h00000013);
    read_chk("full_mem1", 32'h1, 32'h00100093);
    read_chk("full_alias", 32'h41, 32'h00100093);

    // Partial final word, plus read-during-write on mem[0]
    start_load();
    chk("reload_wordCount", wc, 0);
    chk("reload_cpu_rst_n", cpu_rn, 0);
    imAddr = 32'h0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    valid = 1'b1;
    data  = 8'h44;
    @(negedge clk);
    chk("rdw_old_value", im_data, 32'h00000013);
    tick();
    valid = 1'b0;
    chk("rdw_new_value", im_data, 32'h44332211);
    send_byte(8'hAA, 1'b1);
    chk("part_wordCount", wc, 2);
    chk("part_done", done, 1);
    read_chk("part_mem0", 32'h0, 32'h44332211);
    read_chk("part_mem1", 32'h1, 32'h000000AA);
    tick();

    // ld_start coincident with a valid byte, then bytes with random gaps
    start = 1'b1;
    valid = 1'b1;
    data  = 8'hEE;
    last  = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    chk("gap_start_byte_dropped_state", st, 1);
    chk("gap_start_byte_dropped_wc", wc, 0);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(prog[i], i == 7);
    end
    chk("gap_wordCount", wc, 2);
    chk("gap_state", st, 2);
    read_chk("gap_mem0", 32'h0, 32'h00000013);
    read_chk("gap_mem1", 32'h1, 32'h00100093);

    // Overflow on the 4-word instance
    sel = 1'b1;
    tick();
    start_load();
    for (int n = 1; n <= 4; n++)
      for (int k = 0; k < 4; k++) send_byte(8'(n), 1'b0);
    chk("ovf_wc_full", wc, 4);
    chk("ovf_not_yet", ovf, 0);
    send_byte(8'h05, 1'b0);
    chk("ovf_set_first_discard", ovf, 1);
    chk("ovf_ready_drain", ready, 1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h05, 1'b1);
    chk("ovf_done", done, 1);
    chk("ovf_state_run", st, 2);
    chk("ovf_wc_sat", wc, 4);
    chk("ovf_sticky", ovf, 1);
    read_chk("ovf_mem0", 32'h0, 32'h01010101);
    read_chk("ovf_mem1", 32'h1, 32'h02020202);
    read_chk("ovf_mem2", 32'h2, 32'h03030303);
    read_chk("ovf_mem3", 32'h3, 32'h04040404);

    // Reload clears ovf; reset mid-load drops the partial word
    start_load();
    chk("reload_ovf_clear", ovf, 0);
    chk("reload_wc_clear", wc, 0);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    chk("mid_wc", wc, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_state", st, 0);
    chk("midrst_wc", wc, 0);
    chk("midrst_cpu_rst_n", cpu_rn, 0);
    chk("midrst_ready", ready, 0);
    read_chk("midrst_mem0_kept", 32'h0, 32'hA3A2A1A0);
    read_chk("midrst_mem1_old", 32'h1, 32'h02020202);
    repeat (3) tick();
    chk("no_autoboot", st, 0);
    start_load();
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i), i == 3);
    chk("final_wc", wc, 1);
    chk("final_ovf", ovf, 0);
    chk("final_cpu_rst_n", cpu_rn, 1);
    read_chk("final_mem0", 32'h0, 32'hB3B2B1B0);
    read_chk("final_mem1", 32'h1, 32'h02020202);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
